// File: rtl/mem_responder.sv
// Block-granular memory responder behind a cache: serves one fill or one
// write-back at a time from an internal word-addressed backing store.
module mem_responder #(
    parameter int B          = 64,
    parameter int W          = 8,
    parameter int ADD_SZ     = 26,
    parameter int BLK_OFF_SZ = 6,
    parameter int MEM_WORDS  = 4096,
    parameter int LAT        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADD_SZ-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_last,
    input  logic              wvalid,
    output logic              wready,
    input  logic [W-1:0]      wdata,
    output logic              wr_done,
    output logic [31:0]       fill_cnt,
    output logic [31:0]       wb_cnt
);

    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int BLK_AW = MEM_AW - BLK_OFF_SZ;
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_ACK
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [BLK_AW-1:0] blk;
    logic [BLK_OFF_SZ-1:0] beat;
    logic [CNT_W-1:0]  lat_cnt;
    logic [MEM_AW-1:0] mem_addr;
    logic              beat_last;
    logic              accept;
    logic              rd_fire;
    logic              wr_fire;
    logic [W-1:0]      mem [MEM_WORDS];

    // Only the block index is kept, so beat addressing can never leave the block.
    assign mem_addr  = {blk, beat};
    assign beat_last = (beat == '1);
    assign accept    = req_valid && req_ready;
    assign rd_fire   = rsp_valid && rsp_ready;
    assign wr_fire   = wready && wvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        wready    = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_wr) begin
                        state_nx = WR_BURST;
                    end else if (LAT == 1) begin
                        state_nx = RD_BURST;
                    end else begin
                        state_nx = RD_WAIT;
                    end
                end
            end
            // Leave on the edge where the counter steps down to zero, giving LAT cycles to first beat.
            RD_WAIT: begin
                if (lat_cnt <= CNT_W'(1)) begin
                    state_nx = RD_BURST;
                end
            end
            RD_BURST: begin
                rsp_valid = 1'b1;
                if (rsp_ready && beat_last) begin
                    state_nx = IDLE;
                end
            end
            WR_BURST: begin
                wready = 1'b1;
                if (wvalid && beat_last) begin
                    state_nx = WR_ACK;
                end
            end
            WR_ACK: begin
                wr_done  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk      <= '0;
            beat     <= '0;
            lat_cnt  <= '0;
            fill_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (accept) begin
                blk  <= req_addr[MEM_AW-1:BLK_OFF_SZ];
                beat <= '0;
                if (!req_wr) begin
                    lat_cnt <= CNT_W'(LAT - 1);
                end
            end
            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (rd_fire || wr_fire) begin
                beat <= beat + 1'b1;
            end
            if (rd_fire && beat_last) begin
                fill_cnt <= fill_cnt + 32'd1;
            end
            if (wr_done) begin
                wb_cnt <= wb_cnt + 32'd1;
            end
        end
    end

    // Backing store has no reset: contents survive rst, and wready is low while in reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[mem_addr] <= wdata;
        end
    end

    assign rsp_data = rsp_valid ? mem[mem_addr] : '0;
    assign rsp_last = rsp_valid && beat_last;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a word-array model predicts fill beats,
// a negedge monitor pops and compares them and checks stall stability.
module tb_mem_responder;

    localparam int B          = 64;
    localparam int W          = 8;
    localparam int ADD_SZ     = 26;
    localparam int BLK_OFF_SZ = 6;
    localparam int MEM_WORDS  = 4096;
    localparam int LAT        = 4;
    localparam int MEM_AW     = 12;
    localparam int BLK_AW     = MEM_AW - BLK_OFF_SZ;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADD_SZ-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_last;
    logic              wvalid;
    logic              wready;
    logic [W-1:0]      wdata;
    logic              wr_done;
    logic [31:0]       fill_cnt;
    logic [31:0]       wb_cnt;

    mem_responder #(
        .B(B), .W(W), .ADD_SZ(ADD_SZ), .BLK_OFF_SZ(BLK_OFF_SZ),
        .MEM_WORDS(MEM_WORDS), .LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wr_done(wr_done),
        .fill_cnt(fill_cnt), .wb_cnt(wb_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        mon_e;
    logic [W-1:0] model_mem [MEM_WORDS];
    bit           blk_written [MEM_WORDS/B];
    logic [W-1:0] wb_buf [B];
    logic [31:0]  exp_fills;
    logic [31:0]  exp_wbs;
    int           n_checks;
    int           n_fail;
    int           n_writes;
    int           n_done;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT did not respond within the cycle bound, expected a response", name);
    endfunction

    // Monitor: decoupled from stimulus, samples on the falling edge.
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", rsp_valid, 1);
                    check("stall_data", rsp_data, prev_data);
                    check("stall_last", rsp_last, prev_last);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h, expected no beat", rsp_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("fill_data", rsp_data, mon_e.data);
                        check("fill_last", rsp_last, mon_e.last);
                    end
                end
                check("outputs_exclusive", ($countones({req_ready, rsp_valid, wready, wr_done}) <= 1), 1);
                prev_stall = rsp_valid && !rsp_ready;
                prev_data  = rsp_data;
                prev_last  = rsp_last;
                if (wvalid && wready) n_writes++;
                if (wr_done) n_done++;
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_wready", wready, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_fill_cnt", fill_cnt, 0);
        check("rst_wb_cnt", wb_cnt, 0);
    endtask

    task automatic issue(input logic wr, input logic [ADD_SZ-1:0] a, output int ok);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        ok = 0;
        for (int t = 0; t < 50 && ok == 0; t++) begin
            if (req_ready) ok = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (ok == 0) timeout("req_accept");
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: random ready
    task automatic do_fill(input logic [ADD_SZ-1:0] a, input int mode, input bit hold);
        int    base, lat, t, k, ok;
        beat_t e;
        base = (int'(a % MEM_WORDS) / B) * B;
        for (int i = 0; i < B; i++) begin
            e.data = model_mem[base + i];
            e.last = (i == B - 1);
            exp_q.push_back(e);
        end
        exp_fills++;
        rsp_ready = 1'b0;
        issue(1'b0, a, ok);
        if (hold) begin
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = a ^ 26'h40;
        end
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            if (hold) check("busy_req_ready", req_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("fill_latency", lat, LAT);
        k = 0;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = (k % 4 == 0) || (k % 4 == 3);
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            if (hold) check("busy_req_ready", req_ready, 0);
            wvalid = 1'($urandom_range(0, 1));
            wdata  = W'($urandom);
            @(posedge clk); #1;
            t++;
        end
        rsp_ready = 1'b0;
        wvalid    = 1'b0;
        if (t >= 2000) begin
            timeout("fill_beats");
            exp_q.delete();
        end
        check("ready_after_fill", req_ready, 1);
        check("fill_cnt", fill_cnt, exp_fills);
        if (hold) begin
            req_valid = 1'b0;
            @(posedge clk); #1;
            check("idle_after_busy", req_ready, 1);
        end
    endtask

    task automatic do_wb(input logic [ADD_SZ-1:0] a, input bit rnd_gaps, input int gap_beat,
                         input int gap_len, input int abort_at);
        int base, i, gaps, gapped, cyc, t, d, ok, done0, wr0;
        base  = (int'(a % MEM_WORDS) / B) * B;
        done0 = n_done;
        wr0   = n_writes;
        issue(1'b1, a, ok);
        cyc = 1;
        i = 0;
        gaps = 0;
        gapped = 0;
        t = 0;
        while (i < B && t < 2000) begin
            if (i == abort_at) begin
                wvalid = 1'b0;
                rst = 1'b1;
                #1;
                check_reset_vals();
                exp_fills = '0;
                exp_wbs   = '0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("abort_no_wr_done", n_done - done0, 0);
                check("abort_writes", n_writes - wr0, abort_at);
                @(posedge clk); #1;
                return;
            end
            if (i == gap_beat && gapped < gap_len) begin
                wvalid = 1'b0;
                gapped++;
            end else if (rnd_gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
            end else begin
                wvalid = 1'b1;
            end
            wdata = wb_buf[i];
            if (wready) begin
                if (wvalid) begin
                    model_mem[base + i] = wb_buf[i];
                    i++;
                end else begin
                    gaps++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            t++;
        end
        wvalid = 1'b0;
        if (t >= 2000) timeout("wb_beats");
        d = cyc;
        while (!wr_done && d < cyc + 20) begin
            @(posedge clk); #1;
            d++;
        end
        check("wr_done_delay", d, B + 1 + gaps);
        @(posedge clk); #1;
        exp_wbs++;
        check("wr_done_pulse", wr_done, 0);
        check("ready_after_wb", req_ready, 1);
        check("wb_cnt", wb_cnt, exp_wbs);
        check("wr_done_count", n_done - done0, 1);
        check("wb_write_count", n_writes - wr0, B);
        blk_written[base / B] = 1'b1;
    endtask

    initial begin
        logic [ADD_SZ-1:0] a;
        int b;
        n_checks  = 0;
        n_fail    = 0;
        n_writes  = 0;
        n_done    = 0;
        exp_fills = '0;
        exp_wbs   = '0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        wvalid    = 1'b0;
        wdata     = '0;
        #2;
        check_reset_vals();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // write-back 0..63 to 0x40, then fill from inside that block
        for (int i = 0; i < B; i++) wb_buf[i] = W'(i);
        do_wb(26'h0000040, 1'b0, -1, 0, -1);
        do_fill(26'h0000045, 0, 1'b0);

        // fill with backpressure pattern
        do_fill(26'h0000045, 1, 1'b0);

        // write-back with wvalid low across beats 10..12
        for (int i = 0; i < B; i++) wb_buf[i] = W'($urandom);
        do_wb(26'h0000100, 1'b0, 10, 3, -1);
        do_fill(26'h0000100, 0, 1'b0);

        // upper address bits beyond the store depth alias
        for (int i = 0; i < B; i++) wb_buf[i] = W'($urandom);
        do_wb(26'h1000080, 1'b0, -1, 0, -1);
        do_fill(26'h0000080, 0, 1'b0);

        // request held high while a fill is in progress
        do_fill(26'h0000080, 2, 1'b1);

        // randomized traffic over a set of blocks with random upper bits and offsets
        for (int n = 0; n < 30; n++) begin
            b = 8 + int'($urandom_range(0, 7));
            a = ADD_SZ'($urandom);
            a[MEM_AW-1:BLK_OFF_SZ] = BLK_AW'(b);
            if (!blk_written[b] || $urandom_range(0, 2) == 0) begin
                for (int i = 0; i < B; i++) wb_buf[i] = W'($urandom);
                do_wb(a, 1'b1, -1, 0, -1);
            end else begin
                do_fill(a, 2, 1'b0);
            end
        end

        // reset at beat 20 of a write-back over previously written data
        for (int i = 0; i < B; i++) wb_buf[i] = W'($urandom);
        do_wb(26'h00000C0, 1'b0, -1, 0, -1);
        for (int i = 0; i < B; i++) wb_buf[i] = W'($urandom);
        do_wb(26'h00000C0, 1'b0, -1, 0, 20);
        do_fill(26'h00000C0, 0, 1'b0);
        check("final_fill_cnt", fill_cnt, 1);
        check("final_wb_cnt", wb_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter B, default 64: words per cache block.
REQ-002 Parameter W, default 8: bits per word.
REQ-003 Parameter ADD_SZ, default 26: word-address width.
REQ-004 Parameter BLK_OFF_SZ, default 6: block-offset bits, with B = 2^BLK_OFF_SZ.
REQ-005 Parameter MEM_WORDS, default 4096: backing-store depth in words, a power of two and a multiple of B.
REQ-006 Parameter LAT, default 4: read access latency in cycles, LAT >= 1.
REQ-007 Port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port req_valid, input, 1 bit: block request present.
REQ-010 Port req_ready, output, 1 bit: responder accepts a request.
REQ-011 Port req_wr, input, 1 bit: 1 = write-back of a modified block, 0 = block fill.
REQ-012 Port req_addr, input, ADD_SZ bits: word address of the block.
REQ-013 Port rsp_valid, output, 1 bit: fill beat valid.
REQ-014 Port rsp_ready, input, 1 bit: cache accepts the fill beat.
REQ-015 Port rsp_data, output, W bits: fill word.
REQ-016 Port rsp_last, output, 1 bit: final beat of the fill.
REQ-017 Port wvalid, input, 1 bit: write-back beat valid.
REQ-018 Port wready, output, 1 bit: responder accepts the write-back beat.
REQ-019 Port wdata, input, W bits: write-back word.
REQ-020 Port wr_done, output, 1 bit: one-cycle pulse when a write-back has committed.
REQ-021 Port fill_cnt, output, 32 bits: number of completed fills.
REQ-022 Port wb_cnt, output, 32 bits: number of completed write-backs.

Function
REQ-023 The controller SHALL be an FSM with states IDLE, RD_WAIT, RD_BURST, WR_BURST and WR_ACK.
REQ-024 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with req_valid and req_ready both high.
REQ-025 On acceptance, base SHALL be captured as req_addr with the low BLK_OFF_SZ bits forced to 0, taken modulo MEM_WORDS; bits above log2(MEM_WORDS) SHALL be ignored.
REQ-026 Acceptance with req_wr=0 SHALL move to RD_WAIT and load the latency counter with LAT-1.
REQ-027 Acceptance with req_wr=1 SHALL move to WR_BURST.
REQ-028 RD_WAIT SHALL decrement the counter each cycle and move to RD_BURST when it reaches 0, so that the first rsp_valid occurs exactly LAT cycles after acceptance.
REQ-029 In RD_BURST, rsp_valid SHALL be 1 and rsp_data SHALL equal mem[base+beat], with beat running 0..B-1.
REQ-030 The beat counter SHALL advance only when rsp_valid and rsp_ready are both high.
REQ-031 While rsp_ready=0, rsp_data and rsp_last SHALL be held stable.
REQ-032 rsp_last SHALL be 1 only on beat B-1.
REQ-033 The handshake on beat B-1 SHALL increment fill_cnt and return the FSM to IDLE; req_ready SHALL be 1 on the next cycle.
REQ-034 In WR_BURST, wready SHALL be 1.
REQ-035 Each wvalid&wready cycle SHALL write wdata to mem[base+beat] and advance beat.
REQ-036 While wvalid=0 in WR_BURST, the FSM SHALL hold with no write.
REQ-037 The write of beat B-1 SHALL move the FSM to WR_ACK.
REQ-038 WR_ACK SHALL last one cycle: wr_done=1, wb_cnt increments, then the FSM returns to IDLE.
REQ-039 rsp_valid SHALL be 0 outside RD_BURST, wready SHALL be 0 outside WR_BURST, and wr_done SHALL be 0 outside WR_ACK.
REQ-040 Beat addressing SHALL stay within the block: base+beat never crosses the block boundary.
REQ-041 fill_cnt and wb_cnt SHALL wrap modulo 2^32.
REQ-042 req_valid outside IDLE SHALL be ignored and not queued; wvalid outside WR_BURST SHALL be ignored.
REQ-043 A read of a block that has just been written back SHALL return the new data with no hazard, since accesses are serialized.

Reset
REQ-044 rst=1 SHALL immediately force: FSM to IDLE, beat=0, latency counter=0, req_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, wready=0, wr_done=0, fill_cnt=0, wb_cnt=0.
REQ-045 Reset in the middle of a burst SHALL abort it without a counter update; memory words already written SHALL be retained, and memory contents SHALL not be cleared by reset.

Verification
REQ-046 Write-back then fill: write-back to addr 0x0000040 with wdata=0..63 -> wr_done pulses once and wb_cnt=1; fill at 0x0000045 -> first rsp_valid exactly 4 cycles after acceptance, data 0..63, rsp_last on the 64th beat, fill_cnt=1.
REQ-047 Fill backpressure: rsp_ready toggled 1,0,0,1 during a fill -> no beats dropped or duplicated, and rsp_data held stable during the stall cycles.
REQ-048 Write-back gaps: wvalid deasserted on beats 10-12 -> exactly 64 writes occur, and wr_done is delayed by exactly 3 cycles.
REQ-049 Address aliasing: write-back to addr 0x1000000 + 0x80 -> a fill at 0x80 returns the same data (MEM_WORDS=4096 aliasing).
REQ-050 Request while busy: req_valid held high during a fill -> req_ready=0 and no second accept until the cycle after rsp_last.
REQ-051 Reset during a write-back: rst asserted at beat 20 of a write-back -> all outputs take their reset values at once, wb_cnt=0, and a later fill returns beats 0-19 new and 20-63 old.
